fpu_share_arbiter: RTL

- Shares one multi-cycle single-precision FP unit (add/sub/mul/div) between two requesters, e.g. the FP-instruction issue path and the FP test/debug path.
- Accepts a request, issues it to the FP unit with a one-cycle start pulse, waits for done or a timeout, then returns the 32-bit result to the requester that owns the operation.
- Round-robin arbitration; at most one operation is in flight.

---
 rtl/fpu_share_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fpu_share_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle FP unit.
// One operation in flight: accept, start pulse, wait for done or timeout, respond.
module fpu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              resp0_valid,
  output logic              resp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp1_valid,
  output logic              resp1_err,
  output logic [DATA_W-1:0] resp_data,
  output logic              fpu_start,
  output logic [OP_W-1:0]   fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  input  logic              fpu_done,
  input  logic [DATA_W-1:0] fpu_result,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [15:0]       timer_q, timer_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic              start_q, start_d, busy_q, busy_d;
  logic              r0v_q, r0v_d, r1v_q, r1v_d, r0e_q, r0e_d, r1e_q, r1e_d;
  logic              grant0, grant1;

  // Ties go to the requester that was not served last; ready is gated by rst
  // so nothing is granted while the block is held in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && (!req1_valid || last_grant_q)) grant0 = 1'b1;
      else if (req1_valid)                             grant1 = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    timer_d      = timer_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    busy_d       = busy_q;
    start_d      = 1'b0;
    r0v_d        = 1'b0;
    r1v_d        = 1'b0;
    r0e_d        = 1'b0;
    r1e_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          op_d    = grant1 ? req1_op : req0_op;
          a_d     = grant1 ? req1_a  : req0_a;
          b_d     = grant1 ? req1_b  : req0_b;
          timer_d = '0;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // done has priority over a timeout landing in the same cycle
        if (fpu_done) begin
          data_d  = fpu_result;
          r0v_d   = !owner_q;
          r1v_d   = owner_q;
          state_d = RESP;
        end else if (timer_q == TMO_LAST) begin
          data_d  = '0;
          r0v_d   = !owner_q;
          r1v_d   = owner_q;
          r0e_d   = !owner_q;
          r1e_d   = owner_q;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP: begin
        last_grant_d = owner_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      timer_q      <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      r0v_q        <= 1'b0;
      r1v_q        <= 1'b0;
      r0e_q        <= 1'b0;
      r1e_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      timer_q      <= timer_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      r0v_q        <= r0v_d;
      r1v_q        <= r1v_d;
      r0e_q        <= r0e_d;
      r1e_q        <= r1e_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = r0v_q;
  assign resp1_valid = r1v_q;
  assign resp0_err   = r0e_q;
  assign resp1_err   = r1e_q;
  assign resp_data   = data_q;
  assign fpu_start   = start_q;
  assign fpu_op      = op_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign busy        = busy_q;

endmodule
